// File: rtl/coin_acceptor.sv
// Coin front-end: synchronize and debounce the raw sensors, queue accepted coins,
// and replay them as spaced single-cycle pulses re-timed to the falling clock edge.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GAP_CYC      = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             hold,
  input  logic                             coin10_raw,
  input  logic                             coin50_raw,
  output logic                             dollar_10,
  output logic                             dollar_50,
  output logic                             coin_reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  coin_cnt,
  output logic                             fifo_full
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  logic [1:0] w_raw;
  logic [1:0] w_ev;
  assign w_raw = {coin50_raw, coin10_raw};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic          r_meta;
    logic          r_sync;
    logic          r_filt;
    logic [DW-1:0] r_dbc;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
        r_filt <= 1'b0;
        r_dbc  <= '0;
      end else begin
        r_meta <= w_raw[g];
        r_sync <= r_meta;
        if (r_sync != r_filt) begin
          if (r_dbc == DW'(DEBOUNCE_CYC - 1)) begin
            r_filt <= r_sync;
            r_dbc  <= '0;
          end else begin
            r_dbc <= r_dbc + DW'(1);
          end
        end else begin
          r_dbc <= '0;
        end
      end
    end

    // Rising edge of the filtered level, flagged the cycle before it is taken.
    assign w_ev[g] = r_sync & ~r_filt & (r_dbc == DW'(DEBOUNCE_CYC - 1));
  end

  logic                  r_pend;
  logic                  r_rej;
  logic [FIFO_DEPTH-1:0] r_mem;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_adm;
  logic                  w_adm_type;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head;

  // A simultaneous 50 coin is deferred one cycle through r_pend.
  assign w_adm      = w_ev[0] | w_ev[1] | r_pend;
  assign w_adm_type = ~w_ev[0];
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_push     = w_adm & enable & ~w_full;
  assign w_head     = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend  <= 1'b0;
      r_rej   <= 1'b0;
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_pend <= w_ev[0] & w_ev[1];
      r_rej  <= w_adm & ~(enable & ~w_full);
      if (w_push) begin
        r_mem[r_wptr] <= w_adm_type;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_gap_next;
  logic          w_can_issue;
  logic          r_p10;
  logic          r_p50;

  assign w_can_issue = (r_count != '0) & ~hold;
  assign w_pop       = (r_state == S_ISSUE);

  // The GAP exit issues directly so the idle spacing is exactly GAP_CYC cycles.
  always_comb begin
    w_next     = r_state;
    w_gap_next = r_gap;
    case (r_state)
      S_IDLE:  if (w_can_issue) w_next = S_ISSUE;
      S_ISSUE: begin
        w_next     = S_GAP;
        w_gap_next = GW'(GAP_CYC);
      end
      S_GAP: begin
        if (r_gap <= GW'(1)) begin
          w_gap_next = '0;
          w_next     = w_can_issue ? S_ISSUE : S_IDLE;
        end else begin
          w_gap_next = r_gap - GW'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_p10   <= 1'b0;
      r_p50   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gap   <= w_gap_next;
      r_p10   <= w_pop & ~w_head;
      r_p50   <= w_pop & w_head;
    end
  end

  logic r_d10;
  logic r_d50;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_d10 <= 1'b0;
      r_d50 <= 1'b0;
    end else begin
      r_d10 <= r_p10;
      r_d50 <= r_p50;
    end
  end

  assign dollar_10   = r_d10;
  assign dollar_50   = r_d50;
  assign coin_reject = r_rej;
  assign coin_cnt    = r_count;
  assign fifo_full   = w_full;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: debounce, queueing, rejection, pulse spacing and async reset.
module tb_coin_acceptor;
  logic       clk;
  logic       reset;
  logic       enable;
  logic       hold;
  logic       coin10_raw;
  logic       coin50_raw;
  logic       dollar_10;
  logic       dollar_50;
  logic       coin_reject;
  logic [2:0] coin_cnt;
  logic       fifo_full;

  coin_acceptor #(.DEBOUNCE_CYC(4), .FIFO_DEPTH(4), .GAP_CYC(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .coin10_raw(coin10_raw), .coin50_raw(coin50_raw),
    .dollar_10(dollar_10), .dollar_50(dollar_50), .coin_reject(coin_reject),
    .coin_cnt(coin_cnt), .fifo_full(fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc, n10, n50, nrej, wide, overlap, maxcnt, last_p, rise_t;
  int seq[$];
  int gaps[$];
  logic p10, p50;
  bit found;

  initial rise_t = -1;
  always @(posedge dollar_10) rise_t = int'($time);

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n10 = 0; n50 = 0; nrej = 0; wide = 0; overlap = 0; maxcnt = 0; last_p = -1;
    seq.delete();
    gaps.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dollar_10 && p10) wide++;
    if (dollar_50 && p50) wide++;
    p10 = dollar_10;
    p50 = dollar_50;
    if (dollar_10 && dollar_50) overlap++;
    if (dollar_10 || dollar_50) begin
      seq.push_back(dollar_50 ? 1 : 0);
      if (last_p >= 0) gaps.push_back(cyc - last_p - 1);
      last_p = cyc;
    end
    if (dollar_10) n10++;
    if (dollar_50) n50++;
    if (coin_reject) nrej++;
    if (int'(coin_cnt) > maxcnt) maxcnt = int'(coin_cnt);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic coin(input bit is50, input int hi);
    if (is50) coin50_raw = 1'b1; else coin10_raw = 1'b1;
    ticks(hi);
    coin10_raw = 1'b0;
    coin50_raw = 1'b0;
    ticks(12);
  endtask

  initial begin
    cyc = 0; p10 = 1'b0; p50 = 1'b0;
    reset = 1'b0; enable = 1'b0; hold = 1'b0;
    coin10_raw = 1'b0; coin50_raw = 1'b0;
    clr();
    ticks(3);
    chk("rst_d10", int'(dollar_10), 0);
    chk("rst_d50", int'(dollar_50), 0);
    chk("rst_rej", int'(coin_reject), 0);
    chk("rst_cnt", int'(coin_cnt), 0);
    chk("rst_full", int'(fifo_full), 0);
    reset = 1'b1;
    enable = 1'b1;
    ticks(3);

    // 1: single 10 coin
    clr();
    coin(1'b0, 10);
    ticks(5);
    chk("t1_n10", n10, 1);
    chk("t1_n50", n50, 0);
    chk("t1_rej", nrej, 0);
    chk("t1_wide", wide, 0);
    chk("t1_negedge", rise_t % 10, 0);
    chk("t1_maxcnt", maxcnt, 1);
    chk("t1_cnt", int'(coin_cnt), 0);

    // 2: short glitch on the 50 sensor
    clr();
    coin50_raw = 1'b1;
    ticks(2);
    coin50_raw = 1'b0;
    ticks(15);
    chk("t2_n50", n50 + n10, 0);
    chk("t2_rej", nrej, 0);
    chk("t2_maxcnt", maxcnt, 0);

    // 3: six coins while held, then release
    clr();
    hold = 1'b1;
    coin(1'b0, 10); coin(1'b1, 10); coin(1'b0, 10);
    coin(1'b0, 10); coin(1'b1, 10); coin(1'b1, 10);
    chk("t3_held_pulses", n10 + n50, 0);
    chk("t3_cnt", int'(coin_cnt), 4);
    chk("t3_full", int'(fifo_full), 1);
    chk("t3_rej", nrej, 2);
    clr();
    hold = 1'b0;
    ticks(20);
    chk("t3_npulse", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_seq%0d", i), (i < seq.size()) ? seq[i] : -1, (i == 1) ? 1 : 0);
    chk("t3_ngap", gaps.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3_gap%0d", i), (i < gaps.size()) ? gaps[i] : -1, 1);
    chk("t3_wide", wide, 0);
    chk("t3_cnt_end", int'(coin_cnt), 0);
    chk("t3_full_end", int'(fifo_full), 0);

    // 4: both sensors rise together
    clr();
    coin10_raw = 1'b1;
    coin50_raw = 1'b1;
    ticks(10);
    coin10_raw = 1'b0;
    coin50_raw = 1'b0;
    ticks(15);
    chk("t4_npulse", seq.size(), 2);
    chk("t4_first", (seq.size() > 0) ? seq[0] : -1, 0);
    chk("t4_second", (seq.size() > 1) ? seq[1] : -1, 1);
    chk("t4_overlap", overlap, 0);
    chk("t4_maxcnt", maxcnt, 2);
    chk("t4_rej", nrej, 0);

    // 5: coin while disabled
    clr();
    enable = 1'b0;
    coin(1'b0, 10);
    ticks(5);
    chk("t5_rej", nrej, 1);
    chk("t5_maxcnt", maxcnt, 0);
    chk("t5_pulses", n10 + n50, 0);
    enable = 1'b1;

    // 6: async reset during a pulse with coins queued
    clr();
    hold = 1'b1;
    coin(1'b0, 10); coin(1'b1, 10); coin(1'b0, 10);
    chk("t6_cnt", int'(coin_cnt), 3);
    hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dollar_10) found = 1'b1;
    end
    chk("t6_found_pulse", int'(found), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_d10", int'(dollar_10), 0);
    chk("t6_d50", int'(dollar_50), 0);
    chk("t6_cnt0", int'(coin_cnt), 0);
    chk("t6_rej", int'(coin_reject), 0);
    ticks(2);
    reset = 1'b1;
    clr();
    ticks(30);
    chk("t6_after", n10 + n50, 0);
    chk("t6_cnt_after", int'(coin_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
